// File: rtl/fns_lane_pipe.sv
// Multi-lane mode-selected operation pipe: one register stage (S1) feeding an
// in-order output FIFO with valid/ready flow control and per-lane accumulators.
module fns_lane_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   mode,
  input  logic [LANES*WIDTH-1:0]       a,
  input  logic [LANES*WIDTH-1:0]       b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [2:0]                   out_mode,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int DW = LANES * WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_XOR   = 3'd0,
    OP_PACK  = 3'd1,
    OP_AND1  = 3'd2,
    OP_LTMIX = 3'd3,
    OP_LTS   = 3'd4,
    OP_ACC   = 3'd5,
    OP_CLR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  logic              s1_valid;
  op_e               s1_op;
  logic [DW-1:0]     s1_a;
  logic [DW-1:0]     s1_b;

  logic [WIDTH-1:0]  acc     [LANES];
  logic [WIDTH-1:0]  acc_nxt [LANES];
  logic [DW-1:0]     res;

  logic [DW-1:0]     fifo_data [DEPTH];
  logic [2:0]        fifo_mode [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic [CW:0]       occ;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the beat in S1 so that S1 can always drain into the FIFO.
  always_comb begin
    occ      = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    in_ready = rst_n && (occ < (CW+1)'(DEPTH));
  end

  assign accept    = in_valid && in_ready;
  assign push      = s1_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data[rd_ptr];
  assign out_mode  = fifo_mode[rd_ptr];

  always_comb begin
    res     = '0;
    acc_nxt = acc;
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [WIDTH-1:0] la;
      logic [WIDTH-1:0] lb;
      logic [WIDTH-1:0] lr;
      la = s1_a[i*WIDTH +: WIDTH];
      lb = s1_b[i*WIDTH +: WIDTH];
      lr = '0;
      unique case (s1_op)
        OP_XOR:   lr = la ^ lb;
        OP_PACK: begin
          lr[2] = 1'b1;
          lr[1] = la[0];
          lr[0] = lb[0];
        end
        OP_AND1:  lr[0] = la[0] & lb[0];
        // a is nominally signed, b unsigned: the mix makes the compare unsigned
        OP_LTMIX: lr[0] = (la < lb);
        OP_LTS:   lr[0] = ($signed(la) < $signed(lb));
        OP_ACC: begin
          acc_nxt[i] = acc[i] + la;
          lr         = acc_nxt[i];
        end
        OP_CLR:   acc_nxt[i] = '0;
        OP_RSVD:  lr = '0;
        default:  lr = '0;
      endcase
      res[i*WIDTH +: WIDTH] = lr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_XOR;
      s1_a      <= '0;
      s1_b      <= '0;
      err       <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      acc       <= '{default: '0};
      fifo_data <= '{default: '0};
      fifo_mode <= '{default: '0};
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= op_e'(mode);
        s1_a  <= a;
        s1_b  <= b;
      end

      // Accumulators and err commit only when the beat retires into the FIFO.
      if (push) begin
        fifo_data[wr_ptr] <= res;
        fifo_mode[wr_ptr] <= s1_op;
        wr_ptr            <= ptr_inc(wr_ptr);
        acc               <= acc_nxt;
        if (s1_op == OP_RSVD) begin
          err <= 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fns_lane_pipe.sv
// Bench for fns_lane_pipe: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a lane-arithmetic reference model.
module tb_fns_lane_pipe;

  localparam int W = 8;
  localparam int L = 2;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_mode;
  logic        err;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  int unsigned mdl_acc [L];
  logic        mdl_err;

  logic [15:0] exp_q [$];
  logic [2:0]  mode_q [$];

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];

  fns_lane_pipe #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = '0;
    a         = '0;
    b         = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [15:0] va, input logic [15:0] vb);
    int n;
    n        = 0;
    mode     = m;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] d, output logic [2:0] m);
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("recv_valid", 32'(out_valid), 32'd1);
    d = out_data;
    m = out_mode;
    step();
    out_ready = 1'b0;
  endtask

  // Reference: each lane computed from integer values of its operands.
  task automatic model(input logic [2:0] m, input logic [15:0] va, input logic [15:0] vb,
                       output logic [15:0] r);
    int unsigned ua, ub, y;
    int          sa, sb;
    r = '0;
    for (int l = 0; l < L; l++) begin
      ua = (32'(va) >> (l * W)) % 256;
      ub = (32'(vb) >> (l * W)) % 256;
      sa = (ua >= 128) ? int'(ua) - 256 : int'(ua);
      sb = (ub >= 128) ? int'(ub) - 256 : int'(ub);
      case (m)
        3'd0: y = ua ^ ub;
        3'd1: y = 4 + 2 * (ua % 2) + (ub % 2);
        3'd2: y = (ua % 2) * (ub % 2);
        3'd3: y = (ua < ub) ? 1 : 0;
        3'd4: y = (sa < sb) ? 1 : 0;
        3'd5: begin
          mdl_acc[l] = (mdl_acc[l] + ua) % 256;
          y          = mdl_acc[l];
        end
        3'd6: begin
          mdl_acc[l] = 0;
          y          = 0;
        end
        default: begin
          y       = 0;
          mdl_err = 1'b1;
        end
      endcase
      r = r | 16'(y << (l * W));
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [2:0]  m;
    logic [15:0] r;
    logic [15:0] va;
    int          n_acc;
    int          sent;
    int          n;

    tbl[0]  = '{3'd0, 16'h0FF0, 16'hFFFF, 16'hF00F};
    tbl[1]  = '{3'd3, 16'h00FF, 16'h0001, 16'h0000};
    tbl[2]  = '{3'd4, 16'h00FF, 16'h0001, 16'h0001};
    tbl[3]  = '{3'd3, 16'h807F, 16'h7F80, 16'h0001};
    tbl[4]  = '{3'd4, 16'h807F, 16'h7F80, 16'h0100};
    tbl[5]  = '{3'd1, 16'h0001, 16'h0000, 16'h0406};
    tbl[6]  = '{3'd2, 16'h0303, 16'h0101, 16'h0101};
    tbl[7]  = '{3'd5, 16'h8080, 16'h5A5A, 16'h8080};
    tbl[8]  = '{3'd5, 16'h8080, 16'hA5A5, 16'h0000};
    tbl[9]  = '{3'd5, 16'h8080, 16'h0000, 16'h8080};
    tbl[10] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[11] = '{3'd5, 16'h0102, 16'h3333, 16'h0102};

    // Reset state, including in_ready held low while rst_n is low.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = '0;
    a         = '0;
    b         = '0;
    step();
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);

    // Latency: not visible after the accept edge, visible one edge later.
    send(3'd0, 16'h0FF0, 16'hFFFF);
    chk("lat_valid_k", 32'(out_valid), 32'd0);
    step();
    chk("lat_valid_k1", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'hF00F);
    chk("lat_mode", 32'(out_mode), 32'd0);
    chk("lat_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_count_pop", 32'(count), 32'd0);

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].mode, tbl[i].a, tbl[i].b);
      recv(d, m);
      chk("tbl_data", 32'(d), 32'(tbl[i].exp));
      chk("tbl_mode", 32'(m), 32'(tbl[i].mode));
    end

    // Reserved mode: zero result, sticky err survives the pop.
    send(3'd7, 16'hFFFF, 16'hFFFF);
    recv(d, m);
    chk("rsvd_data", 32'(d), 32'd0);
    chk("rsvd_mode", 32'(m), 32'd7);
    chk("rsvd_err_after_pop", 32'(err), 32'd1);
    step();
    chk("rsvd_err_sticky", 32'(err), 32'd1);

    // Backpressure: FIFO plus S1 admit exactly DEPTH beats.
    n_acc     = 0;
    va        = 16'h1111;
    mode      = 3'd0;
    b         = 16'h0000;
    a         = va;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) n_acc++;
      step();
      a = 16'(16'h1111 * (n_acc + 1));
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(n_acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    chk("bp_head0", 32'(out_data), 32'h1111);
    step();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_count1", 32'(count), 32'd1);
    chk("bp_head1", 32'(out_data), 32'h2222);
    step();
    out_ready = 1'b0;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with a full FIFO and err set discards everything.
    in_valid = 1'b1;
    a        = 16'h5555;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    chk("rf_full_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    step();
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_count", 32'(count), 32'd0);
    chk("rf_err", 32'(err), 32'd0);
    chk("rf_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    send(3'd5, 16'h0101, 16'h0000);
    recv(d, m);
    chk("rf_acc_data", 32'(d), 32'h0101);

    // Randomized traffic against the reference model.
    do_reset();
    mdl_acc = '{default: 0};
    mdl_err = 1'b0;
    sent    = 0;
    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 3'($urandom_range(0, 7));
      a         = 16'($urandom);
      b         = 16'($urandom);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 32'(out_valid), 32'd0);
        end else begin
          chk("rnd_data", 32'(out_data), 32'(exp_q.pop_front()));
          chk("rnd_mode", 32'(out_mode), 32'(mode_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        model(mode, a, b, r);
        exp_q.push_back(r);
        mode_q.push_back(mode);
        sent++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = 0;
    while (exp_q.size() > 0 && n < 50) begin
      if (out_valid) begin
        chk("rnd_drain_data", 32'(out_data), 32'(exp_q.pop_front()));
        chk("rnd_drain_mode", 32'(out_mode), 32'(mode_q.pop_front()));
      end
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("rnd_leftover", 32'(exp_q.size()), 32'd0);
    chk("rnd_count", 32'(count), 32'd0);
    chk("rnd_err", 32'(err), 32'(mdl_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
